// File: rtl/asg_out_fade.sv
// rtl/asg_out_fade.sv - per-channel DAC output fade-in/fade-out gain ramp with slew-rate limiter
module asg_out_fade #(
    parameter int DW = 14,
    parameter int GW = 16
) (
    input  logic          dac_clk_i,
    input  logic          dac_rstn_i,
    input  logic [DW-1:0] dat_i,
    input  logic          en_i,
    input  logic [GW-1:0] fade_step_i,
    input  logic [DW-1:0] slew_i,
    output logic [DW-1:0] dac_o,
    output logic [1:0]    state_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [GW:0]   FULL   = {1'b1, {GW{1'b0}}};
    localparam logic [GW+1:0] FULL_X = {1'b0, FULL};

    state_t        state;
    logic [GW:0]   g;
    logic [GW+1:0] g_up;
    logic          step_zero;
    logic          step_covers;

    assign g_up        = {1'b0, g} + {2'b00, fade_step_i};
    assign step_zero   = (fade_step_i == '0);
    assign step_covers = (g <= {1'b0, fade_step_i});
    assign state_o     = state;

    // Fade controller: fade_step_i is used live, so a step change mid-ramp applies immediately.
    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            state <= ST_OFF;
            g     <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    g <= '0;
                    if (en_i) begin
                        if (step_zero) begin
                            g     <= FULL;
                            state <= ST_ON;
                        end else begin
                            state <= ST_RAMP_UP;
                        end
                    end
                end
                ST_RAMP_UP: begin
                    if (step_zero) begin
                        g     <= en_i ? FULL : '0;
                        state <= en_i ? ST_ON : ST_OFF;
                    end else if (en_i) begin
                        if (g_up >= FULL_X) begin
                            g     <= FULL;
                            state <= ST_ON;
                        end else begin
                            g <= g_up[GW:0];
                        end
                    end else begin
                        state <= ST_RAMP_DOWN;
                    end
                end
                ST_ON: begin
                    g <= FULL;
                    if (!en_i) begin
                        if (step_zero) begin
                            g     <= '0;
                            state <= ST_OFF;
                        end else begin
                            state <= ST_RAMP_DOWN;
                        end
                    end
                end
                default: begin
                    if (step_zero) begin
                        g     <= en_i ? FULL : '0;
                        state <= en_i ? ST_ON : ST_OFF;
                    end else if (!en_i) begin
                        if (step_covers) begin
                            g     <= '0;
                            state <= ST_OFF;
                        end else begin
                            g <= g - {1'b0, fade_step_i};
                        end
                    end else begin
                        state <= ST_RAMP_UP;
                    end
                end
            endcase
        end
    end

    logic signed [DW-1:0]    s1_dat;
    logic [GW:0]             s1_g;
    logic                    s1_ramp;
    logic signed [DW-1:0]    s2_scaled;
    logic                    s2_ramp;
    logic signed [DW+GW+1:0] dat_x;
    logic signed [DW+GW+1:0] g_x;
    logic signed [DW+GW+1:0] prod;

    assign dat_x = {{(GW+2){s1_dat[DW-1]}}, s1_dat};
    assign g_x   = {{(DW+1){1'b0}}, s1_g};
    assign prod  = dat_x * g_x;

    // Gain never exceeds FULL, so the floored product always fits back into DW bits.
    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            s1_dat    <= '0;
            s1_g      <= '0;
            s1_ramp   <= 1'b0;
            s2_scaled <= '0;
            s2_ramp   <= 1'b0;
        end else begin
            s1_dat    <= dat_i;
            s1_g      <= g;
            s1_ramp   <= (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
            s2_scaled <= DW'(prod >>> GW);
            s2_ramp   <= s1_ramp;
        end
    end

    logic signed [DW:0] diff;
    logic signed [DW:0] slew_pos;
    logic signed [DW:0] slew_neg;
    logic               slew_on;

    // One extra bit keeps the difference between opposite full-scale codes from wrapping.
    assign diff     = {s2_scaled[DW-1], s2_scaled} - {dac_o[DW-1], dac_o};
    assign slew_pos = {1'b0, slew_i};
    assign slew_neg = -slew_pos;
    assign slew_on  = (slew_i != '0);

    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            dac_o  <= '0;
            busy_o <= 1'b0;
        end else if (slew_on && (diff > slew_pos)) begin
            dac_o  <= dac_o + slew_i;
            busy_o <= 1'b1;
        end else if (slew_on && (diff < slew_neg)) begin
            dac_o  <= dac_o - slew_i;
            busy_o <= 1'b1;
        end else begin
            dac_o  <= s2_scaled;
            busy_o <= s2_ramp;
        end
    end

endmodule

// File: tb/tb_asg_out_fade.sv
// tb/tb_asg_out_fade.sv - table, directed and randomized checks of asg_out_fade against a reference model
module tb_asg_out_fade;

    localparam int FULL = 65536;

    logic        clk = 1'b0;
    logic        rstn;
    logic [13:0] dat_i;
    logic        en;
    logic [15:0] step;
    logic [13:0] slew;
    logic [13:0] dac_o;
    logic [1:0]  state_o;
    logic        busy_o;

    int cur_dat;
    int nvec = 0;
    int nfail = 0;

    int m_mode, m_g, m_dac, m_busy;
    int tq[$];
    int rq[$];

    asg_out_fade dut (
        .dac_clk_i  (clk),
        .dac_rstn_i (rstn),
        .dat_i      (dat_i),
        .en_i       (en),
        .fade_step_i(step),
        .slew_i     (slew),
        .dac_o      (dac_o),
        .state_o    (state_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    function automatic int fscale(int d, int gain);
        longint p = longint'(d) * longint'(gain);
        longint q = p / FULL;
        if (p < 0 && (p % FULL) != 0) q = q - 1;
        return int'(q);
    endfunction

    task automatic model_step();
        int t, r, d, s, st;
        if (!rstn) begin
            m_mode = 0; m_g = 0; m_dac = 0; m_busy = 0;
            tq.delete(); rq.delete();
            return;
        end
        s  = int'(slew);
        st = int'(step);
        tq.push_back(fscale(cur_dat, m_g));
        rq.push_back((m_mode == 1 || m_mode == 3) ? 1 : 0);
        if (tq.size() > 2) begin
            t = tq.pop_front();
            r = rq.pop_front();
            d = t - m_dac;
            if (s != 0 && d > s) begin
                m_dac = m_dac + s; m_busy = 1;
            end else if (s != 0 && d < -s) begin
                m_dac = m_dac - s; m_busy = 1;
            end else begin
                m_dac = t; m_busy = r;
            end
        end
        case (m_mode)
            0: if (en) begin
                if (st == 0) begin m_g = FULL; m_mode = 2; end
                else m_mode = 1;
            end
            1: if (st == 0) begin
                m_mode = en ? 2 : 0; m_g = en ? FULL : 0;
            end else if (en) begin
                if (m_g + st >= FULL) begin m_g = FULL; m_mode = 2; end
                else m_g = m_g + st;
            end else m_mode = 3;
            2: if (!en) begin
                if (st == 0) begin m_g = 0; m_mode = 0; end
                else m_mode = 3;
            end
            default: if (st == 0) begin
                m_mode = en ? 2 : 0; m_g = en ? FULL : 0;
            end else if (!en) begin
                if (m_g <= st) begin m_g = 0; m_mode = 0; end
                else m_g = m_g - st;
            end else m_mode = 1;
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sdac();
        return int'($signed(dac_o));
    endfunction

    task automatic drive(input int d);
        cur_dat = d;
        dat_i   = cur_dat[13:0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("dac", sdac(), m_dac);
        chk("state", int'(state_o), m_mode);
        chk("busy", int'(busy_o), m_busy);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    typedef struct {
        int dac;
        int st;
        int busy;
    } vec_t;

    vec_t fade_tab[9];

    initial begin
        int maxabs;
        rstn = 1'b0; en = 1'b0; step = '0; slew = '0;
        drive(0);

        fade_tab[0] = '{0, 1, 0};
        fade_tab[1] = '{0, 1, 0};
        fade_tab[2] = '{0, 1, 0};
        fade_tab[3] = '{0, 1, 1};
        fade_tab[4] = '{2047, 2, 1};
        fade_tab[5] = '{4095, 2, 1};
        fade_tab[6] = '{6143, 2, 1};
        fade_tab[7] = '{8191, 2, 0};
        fade_tab[8] = '{8191, 2, 0};

        do_reset();
        chk("rst_dac", sdac(), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_busy", int'(busy_o), 0);

        // fade-in table: dat 8191, step FULL/4
        en = 1'b1; step = 16'd16384; drive(8191);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("tab_dac", sdac(), fade_tab[i].dac);
            chk("tab_state", int'(state_o), fade_tab[i].st);
            chk("tab_busy", int'(busy_o), fade_tab[i].busy);
        end

        // pass-through including extremes
        do_reset();
        en = 1'b1; step = '0; slew = '0;
        for (int v = -100; v <= 100; v += 7) begin
            drive(v);
            tick();
        end
        drive(-8192); tick();
        drive(8191);  tick();
        drive(-8192); tick();
        drive(0);
        for (int i = 0; i < 3; i++) tick();

        // fade-out and reversal
        do_reset();
        en = 1'b1; step = '0; drive(-4000);
        for (int i = 0; i < 6; i++) tick();
        step = 16'd8192; en = 1'b0;
        maxabs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sdac() > maxabs || -sdac() > maxabs) maxabs = (sdac() < 0) ? -sdac() : sdac();
        end
        chk("rev_down_state", int'(state_o), 3);
        en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (sdac() > maxabs || -sdac() > maxabs) maxabs = (sdac() < 0) ? -sdac() : sdac();
        end
        chk("rev_bound", (maxabs <= 4000) ? 1 : 0, 1);
        chk("rev_final", sdac(), -4000);

        // slew up to 8191 then down to -8192
        do_reset();
        en = 1'b1; step = '0; slew = 14'd1000; drive(0);
        for (int i = 0; i < 6; i++) tick();
        drive(8191);
        for (int i = 0; i < 14; i++) tick();
        chk("slew_top", sdac(), 8191);
        drive(-8192);
        for (int i = 0; i < 22; i++) tick();
        chk("slew_bot", sdac(), -8192);
        slew = '0;

        // reset mid-ramp
        do_reset();
        en = 1'b1; step = 16'd4096; drive(5000);
        for (int i = 0; i < 12; i++) tick();
        rstn = 1'b0;
        tick();
        chk("midrst_dac", sdac(), 0);
        chk("midrst_state", int'(state_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        rstn = 1'b1;
        tick();
        chk("midrst_restart", int'(state_o), 1);
        for (int i = 0; i < 8; i++) tick();

        // randomized
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(int'($urandom_range(0, 16383)) - 8192);
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: step = '0;
                    1: step = 16'($urandom_range(1, 4096));
                    2: step = 16'd16384;
                    default: step = 16'($urandom_range(0, 65535));
                endcase
            end
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: slew = '0;
                    2: slew = 14'($urandom_range(1, 500));
                    default: slew = 14'($urandom_range(0, 16383));
                endcase
            end
            rstn = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
